// File: rtl/hdr_exposure_scheduler.sv
// HDR exposure scheduler: programs the sensor one frame ahead, alternating short
// and long exposure values over a valid/ready register-write port on each vsync.
module hdr_exposure_scheduler #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter logic [7:0]  ADDR_HI = 8'h35,
    parameter logic [7:0]  ADDR_LO = 8'h36
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        vsync,
    input  logic [15:0] exp_short,
    input  logic [15:0] exp_long,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [7:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    output logic        frame_exp_idx,
    output logic        frame_pair_start,
    output logic        busy,
    output logic        overrun,
    output logic        led
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HI   = 2'd1,
        WR_LO   = 2'd2,
        WAIT_VS = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        vsync_q;
    logic        next_idx;
    logic [15:0] value;

    logic vs_edge;
    logic frame_evt;    // a frame boundary is accepted: advance the index
    logic reprogram;    // load the exposure for the frame after the arriving one
    logic load_short;   // first write after enabling always uses exp_short
    logic set_overrun;
    logic clear_idx;

    assign vs_edge = vsync & ~vsync_q;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cfg_valid   = 1'b0;
        cfg_addr    = 8'h00;
        cfg_data    = 8'h00;
        busy        = 1'b0;
        frame_evt   = 1'b0;
        reprogram   = 1'b0;
        load_short  = 1'b0;
        set_overrun = 1'b0;
        clear_idx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    load_short = 1'b1;
                    state_nxt  = WR_HI;
                end
            end

            WR_HI: begin
                cfg_valid = 1'b1;
                cfg_addr  = ADDR_HI;
                cfg_data  = value[15:8];
                busy      = 1'b1;
                // A frame edge mid-write only advances the index; its write is lost.
                if (enable && vs_edge) begin
                    frame_evt   = 1'b1;
                    set_overrun = 1'b1;
                end
                if (cfg_ready) begin
                    state_nxt = WR_LO;
                end
            end

            WR_LO: begin
                cfg_valid = 1'b1;
                cfg_addr  = ADDR_LO;
                cfg_data  = value[7:0];
                busy      = 1'b1;
                if (cfg_ready) begin
                    if (!enable) begin
                        clear_idx = 1'b1;
                        state_nxt = IDLE;
                    end else if (vs_edge) begin
                        // Edge coincides with the final transfer: the write is done,
                        // so it is an ordinary frame boundary, not an overrun.
                        frame_evt = 1'b1;
                        reprogram = 1'b1;
                        state_nxt = WR_HI;
                    end else begin
                        state_nxt = WAIT_VS;
                    end
                end else if (enable && vs_edge) begin
                    frame_evt   = 1'b1;
                    set_overrun = 1'b1;
                end
            end

            WAIT_VS: begin
                if (!enable) begin
                    clear_idx = 1'b1;
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    frame_evt = 1'b1;
                    reprogram = 1'b1;
                    state_nxt = WR_HI;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the clock edge, independent of statement order.
    // NOTE: the reset is synchronous, and it clears every register including the
    // exposure value; there is no memory array here that would justify leaving one out.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state            <= IDLE;
            vsync_q          <= 1'b0;
            next_idx         <= 1'b0;
            value            <= 16'h0000;
            frame_exp_idx    <= 1'b0;
            frame_pair_start <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            state            <= state_nxt;
            vsync_q          <= vsync;
            frame_pair_start <= frame_evt & ~next_idx;

            if (frame_evt) begin
                frame_exp_idx <= next_idx;
                next_idx      <= ~next_idx;
            end
            if (clear_idx) begin
                next_idx <= 1'b0;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end

            if (load_short) begin
                value <= exp_short;
            end else if (reprogram) begin
                value <= next_idx ? exp_short : exp_long;
            end
        end
    end

    // Heartbeat. A second counter wrapping at CLK_HZ/4 runs in lockstep with the
    // main one, so it equals count mod (CLK_HZ/4) without a divider.
    localparam int unsigned Q_HZ  = CLK_HZ / 4;
    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned Q_W   = (Q_HZ > 1) ? $clog2(Q_HZ) : 1;

    logic [CNT_W-1:0] led_cnt;
    logic [Q_W-1:0]   led_qcnt;

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            led_cnt  <= '0;
            led_qcnt <= '0;
            led      <= 1'b0;
        end else begin
            led_cnt  <= (led_cnt == CNT_W'(CLK_HZ - 1)) ? '0 : led_cnt + 1'b1;
            led_qcnt <= (led_qcnt == Q_W'(Q_HZ - 1)) ? '0 : led_qcnt + 1'b1;
            led      <= overrun ? (led_qcnt < Q_W'(CLK_HZ / 8))
                                : (led_cnt < CNT_W'(CLK_HZ / 2));
        end
    end

endmodule

// File: tb/tb_hdr_exposure_scheduler.sv
// Directed bench for hdr_exposure_scheduler: init write, alternation, backpressure,
// simultaneity, disable, overrun with 4 Hz heartbeat, and reset during a write.
module tb_hdr_exposure_scheduler;

    logic        clk50;
    logic        rst_n;
    logic        enable;
    logic        vsync;
    logic [15:0] exp_short;
    logic [15:0] exp_long;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        frame_exp_idx;
    logic        frame_pair_start;
    logic        busy;
    logic        overrun;
    logic        led;

    int   tests    = 0;
    int   failures = 0;
    int   xfers    = 0;
    int   x0;
    int   highs;
    int   last;
    int   toggles;
    logic prev;

    hdr_exposure_scheduler #(.CLK_HZ(64)) dut (
        .clk50            (clk50),
        .rst_n            (rst_n),
        .enable           (enable),
        .vsync            (vsync),
        .exp_short        (exp_short),
        .exp_long         (exp_long),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .frame_exp_idx    (frame_exp_idx),
        .frame_pair_start (frame_pair_start),
        .busy             (busy),
        .overrun          (overrun),
        .led              (led)
    );

    initial begin
        clk50 = 1'b0;
        forever #5 clk50 = ~clk50;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Handshake transfers, sampled mid-cycle where inputs and outputs are settled.
    always @(negedge clk50) begin
        if (rst_n && cfg_valid && cfg_ready) xfers++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [7:0] addr, input logic [7:0] data);
        check({tag, ".valid"}, cfg_valid, 1'b1);
        check({tag, ".addr"}, cfg_addr, addr);
        check({tag, ".data"}, cfg_data, data);
    endtask

    // One vsync edge from WAIT_VS followed by a complete two-byte write (cfg_ready=1).
    task automatic frame_edge(input string tag, input logic idx, input logic pair,
                              input logic [15:0] val);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check({tag, ".idx"}, frame_exp_idx, idx);
        check({tag, ".pair"}, frame_pair_start, pair);
        check_bus({tag, ".hi"}, 8'h35, val[15:8]);
        tick();
        check({tag, ".pair_end"}, frame_pair_start, 1'b0);
        check_bus({tag, ".lo"}, 8'h36, val[7:0]);
        tick();
        check({tag, ".done"}, cfg_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        vsync     = 1'b0;
        cfg_ready = 1'b0;
        exp_short = 16'h1234;
        exp_long  = 16'hABCD;
        repeat (3) tick();

        check("rst.valid", cfg_valid, 1'b0);
        check("rst.addr", cfg_addr, 8'h00);
        check("rst.data", cfg_data, 8'h00);
        check("rst.idx", frame_exp_idx, 1'b0);
        check("rst.pair", frame_pair_start, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.overrun", overrun, 1'b0);
        check("rst.led", led, 1'b0);

        // 1 Hz heartbeat: first count after reset is 0, so led comes up high.
        rst_n = 1'b1;
        tick();
        check("led.first", led, 1'b1);
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (led) highs++;
        end
        check("led.1hz_duty", highs, 32);
        check("idle.valid", cfg_valid, 1'b0);

        // Initial write of exp_short on enable.
        cfg_ready = 1'b1;
        enable    = 1'b1;
        x0        = xfers;
        tick();
        check_bus("init.hi", 8'h35, 8'h12);
        check("init.busy", busy, 1'b1);
        tick();
        check_bus("init.lo", 8'h36, 8'h34);
        tick();
        check("init.done", cfg_valid, 1'b0);
        check("init.busy_end", busy, 1'b0);
        check("init.xfers", xfers - x0, 2);

        // Alternation: each edge programs the opposite exposure for the next frame.
        frame_edge("alt1", 1'b0, 1'b1, 16'hABCD);
        frame_edge("alt2", 1'b1, 1'b0, 16'h1234);
        frame_edge("alt3", 1'b0, 1'b1, 16'hABCD);
        frame_edge("alt4", 1'b1, 1'b0, 16'h1234);

        // Backpressure: ready low for five cycles in WR_HI.
        cfg_ready = 1'b0;
        vsync     = 1'b1;
        x0        = xfers;
        tick();
        vsync = 1'b0;
        check("bp.idx", frame_exp_idx, 1'b0);
        check("bp.pair", frame_pair_start, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_bus($sformatf("bp.hold%0d", i), 8'h35, 8'hAB);
            cfg_ready = (i == 5);
            tick();
        end
        check_bus("bp.lo", 8'h36, 8'hCD);
        tick();
        check("bp.done", cfg_valid, 1'b0);
        check("bp.xfers", xfers - x0, 2);

        // Edge in the WR_LO transfer cycle goes straight to the next write.
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("sim.idx1", frame_exp_idx, 1'b1);
        check_bus("sim.hi", 8'h35, 8'h12);
        tick();
        check_bus("sim.lo", 8'h36, 8'h34);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("sim.overrun", overrun, 1'b0);
        check("sim.idx0", frame_exp_idx, 1'b0);
        check("sim.pair", frame_pair_start, 1'b1);
        check_bus("sim.rehi", 8'h35, 8'hAB);
        tick();
        check_bus("sim.relo", 8'h36, 8'hCD);
        tick();
        check("sim.done", cfg_valid, 1'b0);

        // Disable during a write: the write completes, then IDLE ignores edges.
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("diswr.idx", frame_exp_idx, 1'b1);
        check_bus("diswr.hi", 8'h35, 8'h12);
        enable = 1'b0;
        tick();
        check_bus("diswr.lo", 8'h36, 8'h34);
        tick();
        check("diswr.idle_valid", cfg_valid, 1'b0);
        check("diswr.idle_busy", busy, 1'b0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("diswr.ign_idx", frame_exp_idx, 1'b1);
        check("diswr.ign_pair", frame_pair_start, 1'b0);
        check("diswr.ign_valid", cfg_valid, 1'b0);
        tick();

        // Re-enable latches the current exp_short.
        exp_short = 16'h5678;
        enable    = 1'b1;
        tick();
        check_bus("reen.hi", 8'h35, 8'h56);
        tick();
        check_bus("reen.lo", 8'h36, 8'h78);
        tick();
        check("reen.done", cfg_valid, 1'b0);
        frame_edge("predis", 1'b0, 1'b1, 16'hABCD);

        // Disable in WAIT_VS clears next_idx; re-enabling restarts at index 0.
        enable = 1'b0;
        tick();
        check("disvs.valid", cfg_valid, 1'b0);
        check("disvs.busy", busy, 1'b0);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("disvs.ign_pair", frame_pair_start, 1'b0);
        check("disvs.ign_valid", cfg_valid, 1'b0);
        tick();
        enable = 1'b1;
        tick();
        check_bus("re2.hi", 8'h35, 8'h56);
        tick();
        check_bus("re2.lo", 8'h36, 8'h78);
        tick();
        check("re2.done", cfg_valid, 1'b0);
        frame_edge("re2.edge", 1'b0, 1'b1, 16'hABCD);

        // Overrun: edge while WR_LO is stalled; write finishes, its successor is dropped.
        x0    = xfers;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("ovr.idx1", frame_exp_idx, 1'b1);
        check_bus("ovr.hi", 8'h35, 8'h56);
        tick();
        check_bus("ovr.lo", 8'h36, 8'h78);
        cfg_ready = 1'b0;
        tick();
        check_bus("ovr.hold", 8'h36, 8'h78);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("ovr.flag", overrun, 1'b1);
        check("ovr.idx0", frame_exp_idx, 1'b0);
        check("ovr.pair", frame_pair_start, 1'b1);
        check_bus("ovr.kept", 8'h36, 8'h78);
        cfg_ready = 1'b1;
        tick();
        check("ovr.dropped", cfg_valid, 1'b0);
        check("ovr.pair_end", frame_pair_start, 1'b0);
        check("ovr.xfers", xfers - x0, 2);

        // 4 Hz heartbeat with CLK_HZ=64: led toggles every 8 cycles.
        prev    = led;
        last    = -1;
        toggles = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (led !== prev) begin
                if (last >= 0) check($sformatf("led.4hz_gap%0d", toggles), i - last, 8);
                last = i;
                toggles++;
                prev = led;
            end
        end
        check("led.4hz_toggles", toggles >= 5, 1'b1);
        check("ovr.sticky", overrun, 1'b1);

        // Reset asserted while WR_LO is stalled.
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("rstw.idx", frame_exp_idx, 1'b1);
        check_bus("rstw.hi", 8'h35, 8'h56);
        tick();
        check_bus("rstw.lo", 8'h36, 8'h78);
        cfg_ready = 1'b0;
        tick();
        check_bus("rstw.hold", 8'h36, 8'h78);
        x0     = xfers;
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        check("rstw.valid", cfg_valid, 1'b0);
        check("rstw.addr", cfg_addr, 8'h00);
        check("rstw.data", cfg_data, 8'h00);
        check("rstw.idx", frame_exp_idx, 1'b0);
        check("rstw.pair", frame_pair_start, 1'b0);
        check("rstw.busy", busy, 1'b0);
        check("rstw.overrun", overrun, 1'b0);
        check("rstw.led", led, 1'b0);
        check("rstw.no_xfer", xfers - x0, 0);
        rst_n = 1'b1;
        tick();
        check("rstw.idle_valid", cfg_valid, 1'b0);
        check("rstw.led_up", led, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hdr_exposure_scheduler.md
HDR_EXPOSURE_SCHEDULER -- requirements
Module: hdr_exposure_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clk50 frequency in Hz, used for LED heartbeat timing.
REQ-002 SHALL have parameter ADDR_HI, default 8'h35: sensor register address for exposure bits [15:8].
REQ-003 SHALL have parameter ADDR_LO, default 8'h36: sensor register address for exposure bits [7:0].
REQ-004 SHALL have port clk50  input  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous to clk50, active-low.
REQ-006 SHALL have port enable  input  1: scheduling enable, level.
REQ-007 SHALL have port vsync  input  1: sensor frame sync, active-high, synchronous to clk50.
REQ-008 SHALL have port exp_short  input  16: short exposure value, used for frames with index 0.
REQ-009 SHALL have port exp_long  input  16: long exposure value, used for frames with index 1.
REQ-010 SHALL have port cfg_valid  output  1: register-write request to the sensor config master.
REQ-011 SHALL have port cfg_ready  input  1: config master accepts the write.
REQ-012 SHALL have port cfg_addr  output  8: register address of the current write.
REQ-013 SHALL have port cfg_data  output  8: register data of the current write.
REQ-014 SHALL have port frame_exp_idx  output  1: exposure index of the frame now arriving.
REQ-015 SHALL have port frame_pair_start  output  1: one-cycle pulse at the start of each index-0 frame.
REQ-016 SHALL have port busy  output  1: high while in WR_HI or WR_LO.
REQ-017 SHALL have port overrun  output  1: sticky flag, a vsync edge arrived during a write.
REQ-018 SHALL have port led  output  1: heartbeat LED.

Function
REQ-019 SHALL implement FSM states IDLE, WR_HI, WR_LO, WAIT_VS.
REQ-020 vsync edge SHALL be defined as vsync=1 in the current cycle with registered vsync=0 in the previous cycle.
REQ-021 IDLE with enable=1 SHALL latch exp_short into a 16-bit value register and go to WR_HI.
REQ-022 WR_HI SHALL drive cfg_valid=1, cfg_addr=ADDR_HI, cfg_data=value[15:8], all held stable until a cycle with cfg_ready=1, then go to WR_LO.
REQ-023 WR_LO SHALL drive cfg_valid=1, cfg_addr=ADDR_LO, cfg_data=value[7:0], held stable until cfg_ready=1, then go to WAIT_VS.
REQ-024 A transfer SHALL occur only in a cycle with cfg_valid=1 and cfg_ready=1, and cfg_valid SHALL NOT drop before that transfer.
REQ-025 The next_idx register SHALL reset to 0.
REQ-026 In WAIT_VS with enable=1 and a vsync edge: frame_exp_idx<=next_idx, next_idx<=~next_idx, value<=(~next_idx ? exp_long : exp_short) sampled in the edge cycle, and go to WR_HI.
REQ-027 The scheduler SHALL pre-program the exposure for the following frame, so the edge at cycle t gives cfg_valid=1 at t+1.
REQ-028 frame_pair_start SHALL pulse one cycle, in the same cycle frame_exp_idx updates, when the newly assigned index is 0.
REQ-029 A vsync edge in WR_HI/WR_LO SHALL set overrun=1 and still update frame_exp_idx/next_idx per REQ-026.
REQ-030 That edge SHALL NOT abort or restart the current write; its exposure write is dropped.
REQ-031 A vsync edge in the same cycle as the WR_LO transfer SHALL be handled as in WAIT_VS (go directly to WR_HI), and SHALL NOT set overrun.
REQ-032 enable=0 in WAIT_VS SHALL go to IDLE and clear next_idx to 0.
REQ-033 enable=0 in WR_HI/WR_LO SHALL let the write complete, then go to IDLE.
REQ-034 Vsync edges while enable=0 or in IDLE SHALL be ignored (no idx change, no pulse).
REQ-035 The LED counter SHALL count 0..CLK_HZ-1 and wrap; led=1 when count<CLK_HZ/2 (1 Hz, 50 % duty).
REQ-036 While overrun=1, led SHALL instead be 1 when (count mod (CLK_HZ/4))<CLK_HZ/8 (4 Hz).

Reset
REQ-037 rst_n=0 at a clk50 edge SHALL force state IDLE; cfg_valid, cfg_addr, cfg_data, frame_exp_idx, frame_pair_start, busy, overrun, led, the LED counter, next_idx, value and registered vsync all 0.
REQ-038 Reset asserted mid-write SHALL drop cfg_valid the next cycle without completing the handshake.
REQ-039 overrun SHALL be cleared only by reset.

Verification
REQ-040 Init write: exp_short=16'h1234, enable 0->1, cfg_ready=1 -> writes (35,12) then (36,34) on consecutive cycles, then WAIT_VS.
REQ-041 Alternation: exp_long=16'hABCD, four vsync edges -> frame_exp_idx 0,1,0,1; writes ABCD,1234,ABCD,1234; frame_pair_start on edges 1 and 3.
REQ-042 Backpressure: cfg_ready low 5 cycles in WR_HI -> cfg_valid/addr/data stable for 6 cycles, single transfer.
REQ-043 Overrun: vsync edge while cfg_ready held low in WR_LO -> overrun=1, index advances, write completes, led toggles every CLK_HZ/8 cycles (use CLK_HZ=64).
REQ-044 Simultaneity/disable: edge in the WR_LO transfer cycle -> WR_HI next, overrun=0; enable=0 in WAIT_VS -> IDLE, later edges ignored, re-enable restarts at idx 0.
REQ-045 Reset: rst_n low during WR_LO -> all outputs 0 next cycle, state IDLE.
